// File: rtl/ram_rw_master.sv
// ============================================================================
// ram_rw_master : core-side ram_rw initiator, IF/LS arbitration, lane align
// Rev 1.0
// ============================================================================
`default_nettype none

module ram_rw_master #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        if_req_valid_i,
   input  logic [63:0] if_req_addr_i,
   output logic        if_req_ready_o,
   output logic        if_resp_valid_o,
   output logic [31:0] if_resp_instr_o,
   output logic        if_resp_err_o,
   input  logic        ls_req_valid_i,
   input  logic        ls_req_wen_i,
   input  logic [63:0] ls_req_addr_i,
   input  logic [63:0] ls_req_wdata_i,
   input  logic [2:0]  ls_req_size_i,
   output logic        ls_req_ready_o,
   output logic        ls_resp_valid_o,
   output logic [63:0] ls_resp_rdata_o,
   output logic        ls_resp_err_o,
   output logic        ram_rw_cen_o,
   output logic        ram_rw_wen_o,
   output logic [63:0] ram_rw_addr_o,
   output logic [63:0] ram_rw_wdata_o,
   output logic [7:0]  ram_rw_wmask_o,
   output logic [2:0]  ram_rw_size_o,
   input  logic        ram_rw_ready_i,
   input  logic [63:0] ram_rw_data_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] c_timeout_last = 8'(TIMEOUT_CYCLES - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [7:0]  r_cnt;

   logic        r_owner_ls;
   logic        r_wen;
   logic [63:0] r_addr;
   logic [2:0]  r_size;
   logic [63:0] r_wdata;
   logic [7:0]  r_wmask;

   logic        r_if_resp_valid;
   logic [31:0] r_if_resp_instr;
   logic        r_if_resp_err;
   logic        r_ls_resp_valid;
   logic [63:0] r_ls_resp_rdata;
   logic        r_ls_resp_err;

   logic        w_accept_ls;
   logic        w_accept_if;
   logic [2:0]  w_ls_off;
   logic        w_ls_mis;
   logic        w_if_mis;
   logic [7:0]  w_base_mask;
   logic [7:0]  w_store_mask;
   logic [63:0] w_store_wdata;
   logic        w_timeout;
   logic [63:0] w_shifted;
   logic [63:0] w_load;
   logic [31:0] w_instr;

   // ------------------------------------------------------------------------
   // Request decode: LS has fixed priority over IF
   // ------------------------------------------------------------------------
   assign w_accept_ls = (r_state == S_IDLE) & ls_req_valid_i & ~reset;
   assign w_accept_if = (r_state == S_IDLE) & if_req_valid_i & ~ls_req_valid_i & ~reset;
   assign w_ls_off    = ls_req_addr_i[2:0];
   assign w_if_mis    = |if_req_addr_i[1:0];

   always_comb begin
      w_ls_mis    = 1'b0;
      w_base_mask = 8'h00;
      case (ls_req_size_i[1:0])
         2'd0: begin w_ls_mis = 1'b0;            w_base_mask = 8'h01; end
         2'd1: begin w_ls_mis = w_ls_off[0];     w_base_mask = 8'h03; end
         2'd2: begin w_ls_mis = |w_ls_off[1:0];  w_base_mask = 8'h0F; end
         default: begin w_ls_mis = |w_ls_off;    w_base_mask = 8'hFF; end
      endcase
   end

   assign w_store_mask  = w_base_mask << w_ls_off;
   assign w_store_wdata = ls_req_wdata_i << {w_ls_off, 3'b000};

   // ------------------------------------------------------------------------
   // Read data formatting
   // ------------------------------------------------------------------------
   assign w_shifted = ram_rw_data_i >> {r_addr[2:0], 3'b000};
   assign w_instr   = r_addr[2] ? ram_rw_data_i[63:32] : ram_rw_data_i[31:0];

   always_comb begin
      w_load = 64'd0;
      case (r_size[1:0])
         2'd0: w_load = r_size[2] ? {56'd0, w_shifted[7:0]}
                                  : {{56{w_shifted[7]}}, w_shifted[7:0]};
         2'd1: w_load = r_size[2] ? {48'd0, w_shifted[15:0]}
                                  : {{48{w_shifted[15]}}, w_shifted[15:0]};
         2'd2: w_load = r_size[2] ? {32'd0, w_shifted[31:0]}
                                  : {{32{w_shifted[31]}}, w_shifted[31:0]};
         default: w_load = w_shifted;
      endcase
   end

   assign w_timeout = (r_state == S_WAIT) & ~ram_rw_ready_i & (r_cnt == c_timeout_last);

   // ------------------------------------------------------------------------
   // FSM: state register and next-state / control outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next   = r_state;
      ls_req_ready_o = 1'b0;
      if_req_ready_o = 1'b0;
      ram_rw_cen_o   = 1'b0;
      busy_o         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            ls_req_ready_o = w_accept_ls;
            if_req_ready_o = w_accept_if;
            if (w_accept_ls)      w_state_next = w_ls_mis ? S_IDLE : S_REQ;
            else if (w_accept_if) w_state_next = w_if_mis ? S_IDLE : S_REQ;
         end
         S_REQ: begin
            ram_rw_cen_o = 1'b1;
            w_state_next = S_WAIT;
         end
         S_WAIT: begin
            if (ram_rw_ready_i || w_timeout) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // Transaction latch, timeout counter and response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt           <= 8'd0;
         r_owner_ls      <= 1'b0;
         r_wen           <= 1'b0;
         r_addr          <= 64'd0;
         r_size          <= 3'd0;
         r_wdata         <= 64'd0;
         r_wmask         <= 8'd0;
         r_if_resp_valid <= 1'b0;
         r_if_resp_instr <= 32'd0;
         r_if_resp_err   <= 1'b0;
         r_ls_resp_valid <= 1'b0;
         r_ls_resp_rdata <= 64'd0;
         r_ls_resp_err   <= 1'b0;
      end else begin
         r_if_resp_valid <= 1'b0;
         r_if_resp_instr <= 32'd0;
         r_if_resp_err   <= 1'b0;
         r_ls_resp_valid <= 1'b0;
         r_ls_resp_rdata <= 64'd0;
         r_ls_resp_err   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Misaligned requests answer immediately and leave the bus untouched
               if (w_accept_ls) begin
                  if (w_ls_mis) begin
                     r_ls_resp_valid <= 1'b1;
                     r_ls_resp_err   <= 1'b1;
                  end else begin
                     r_owner_ls <= 1'b1;
                     r_wen      <= ls_req_wen_i;
                     r_addr     <= ls_req_addr_i;
                     r_size     <= ls_req_size_i;
                     r_wmask    <= ls_req_wen_i ? w_store_mask  : 8'd0;
                     r_wdata    <= ls_req_wen_i ? w_store_wdata : 64'd0;
                  end
               end else if (w_accept_if) begin
                  if (w_if_mis) begin
                     r_if_resp_valid <= 1'b1;
                     r_if_resp_err   <= 1'b1;
                  end else begin
                     r_owner_ls <= 1'b0;
                     r_wen      <= 1'b0;
                     r_addr     <= if_req_addr_i;
                     r_size     <= 3'd2;
                     r_wmask    <= 8'd0;
                     r_wdata    <= 64'd0;
                  end
               end
            end
            S_REQ: begin
               r_cnt <= 8'd0;
            end
            S_WAIT: begin
               if (ram_rw_ready_i) begin
                  if (r_owner_ls) begin
                     r_ls_resp_valid <= 1'b1;
                     r_ls_resp_rdata <= r_wen ? 64'd0 : w_load;
                  end else begin
                     r_if_resp_valid <= 1'b1;
                     r_if_resp_instr <= w_instr;
                  end
               end else if (w_timeout) begin
                  if (r_owner_ls) begin
                     r_ls_resp_valid <= 1'b1;
                     r_ls_resp_err   <= 1'b1;
                  end else begin
                     r_if_resp_valid <= 1'b1;
                     r_if_resp_err   <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign ram_rw_wen_o    = r_wen;
   assign ram_rw_addr_o   = {r_addr[63:3], 3'b000};
   assign ram_rw_wdata_o  = r_wdata;
   assign ram_rw_wmask_o  = r_wmask;
   assign ram_rw_size_o   = {1'b0, r_size[1:0]};

   assign if_resp_valid_o = r_if_resp_valid;
   assign if_resp_instr_o = r_if_resp_instr;
   assign if_resp_err_o   = r_if_resp_err;
   assign ls_resp_valid_o = r_ls_resp_valid;
   assign ls_resp_rdata_o = r_ls_resp_rdata;
   assign ls_resp_err_o   = r_ls_resp_err;

endmodule

`default_nettype wire

// File: tb/tb_ram_rw_master.sv
// ============================================================================
// tb_ram_rw_master : directed table-driven bench for ram_rw_master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ram_rw_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_valid = 1'b0;
   logic [63:0] if_req_addr = '0;
   logic        if_req_ready;
   logic        if_resp_valid;
   logic [31:0] if_resp_instr;
   logic        if_resp_err;
   logic        ls_req_valid = 1'b0;
   logic        ls_req_wen = 1'b0;
   logic [63:0] ls_req_addr = '0;
   logic [63:0] ls_req_wdata = '0;
   logic [2:0]  ls_req_size = '0;
   logic        ls_req_ready;
   logic        ls_resp_valid;
   logic [63:0] ls_resp_rdata;
   logic        ls_resp_err;
   logic        cen, wen;
   logic [63:0] addr, wdata;
   logic [7:0]  wmask;
   logic [2:0]  size;
   logic        ram_ready = 1'b0;
   logic [63:0] ram_data = '0;
   logic        busy;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [63:0] WORD = 64'hFEDC_BA98_7654_3210;

   ram_rw_master #(.TIMEOUT_CYCLES(16)) dut (
      .clock(clk), .reset(rst),
      .if_req_valid_i(if_req_valid), .if_req_addr_i(if_req_addr), .if_req_ready_o(if_req_ready),
      .if_resp_valid_o(if_resp_valid), .if_resp_instr_o(if_resp_instr), .if_resp_err_o(if_resp_err),
      .ls_req_valid_i(ls_req_valid), .ls_req_wen_i(ls_req_wen), .ls_req_addr_i(ls_req_addr),
      .ls_req_wdata_i(ls_req_wdata), .ls_req_size_i(ls_req_size), .ls_req_ready_o(ls_req_ready),
      .ls_resp_valid_o(ls_resp_valid), .ls_resp_rdata_o(ls_resp_rdata), .ls_resp_err_o(ls_resp_err),
      .ram_rw_cen_o(cen), .ram_rw_wen_o(wen), .ram_rw_addr_o(addr), .ram_rw_wdata_o(wdata),
      .ram_rw_wmask_o(wmask), .ram_rw_size_o(size), .ram_rw_ready_i(ram_ready),
      .ram_rw_data_i(ram_data), .busy_o(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wen;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] rdat;
      logic        mis;
      logic [63:0] e_addr;
      logic [7:0]  e_mask;
      logic [63:0] e_wdata;
      logic [63:0] e_rdata;
   } vec_t;

   vec_t vecs[15];

   function automatic vec_t mk(input logic w, input logic [2:0] sz, input logic [63:0] a,
                               input logic [63:0] wd, input logic [63:0] rd, input logic m,
                               input logic [63:0] ea, input logic [7:0] em,
                               input logic [63:0] ew, input logic [63:0] er);
      vec_t v;
      v.wen = w; v.size = sz; v.addr = a; v.wdata = wd; v.rdat = rd; v.mis = m;
      v.e_addr = ea; v.e_mask = em; v.e_wdata = ew; v.e_rdata = er;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_ls(input int idx, input vec_t v);
      @(negedge clk);
      ls_req_valid = 1'b1; ls_req_wen = v.wen; ls_req_addr = v.addr;
      ls_req_wdata = v.wdata; ls_req_size = v.size;
      #1 chk($sformatf("v%0d_req_ready", idx), 64'(ls_req_ready), 64'd1);
      @(negedge clk);
      ls_req_valid = 1'b0;
      if (v.mis) begin
         chk($sformatf("v%0d_mis_cen", idx), 64'(cen), 64'd0);
         chk($sformatf("v%0d_mis_valid", idx), 64'(ls_resp_valid), 64'd1);
         chk($sformatf("v%0d_mis_err", idx), 64'(ls_resp_err), 64'd1);
         chk($sformatf("v%0d_mis_rdata", idx), ls_resp_rdata, 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_mis_pulse", idx), 64'(ls_resp_valid), 64'd0);
      end else begin
         chk($sformatf("v%0d_cen", idx), 64'(cen), 64'd1);
         chk($sformatf("v%0d_addr", idx), addr, v.e_addr);
         chk($sformatf("v%0d_wen", idx), 64'(wen), 64'(v.wen));
         chk($sformatf("v%0d_wmask", idx), 64'(wmask), 64'(v.e_mask));
         chk($sformatf("v%0d_wdata", idx), wdata, v.e_wdata);
         chk($sformatf("v%0d_size", idx), 64'(size), 64'({1'b0, v.size[1:0]}));
         @(negedge clk);
         ram_ready = 1'b1; ram_data = v.rdat;
         chk($sformatf("v%0d_cen_once", idx), 64'(cen), 64'd0);
         chk($sformatf("v%0d_early_valid", idx), 64'(ls_resp_valid), 64'd0);
         @(negedge clk);
         ram_ready = 1'b0; ram_data = '0;
         chk($sformatf("v%0d_valid", idx), 64'(ls_resp_valid), 64'd1);
         chk($sformatf("v%0d_rdata", idx), ls_resp_rdata, v.e_rdata);
         chk($sformatf("v%0d_err", idx), 64'(ls_resp_err), 64'd0);
         chk($sformatf("v%0d_if_quiet", idx), 64'(if_resp_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d_pulse", idx), 64'(ls_resp_valid), 64'd0);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cen"}, 64'(cen), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_ls_valid"}, 64'(ls_resp_valid), 64'd0);
      chk({tag, "_if_valid"}, 64'(if_resp_valid), 64'd0);
      chk({tag, "_addr"}, addr, 64'd0);
      chk({tag, "_wdata"}, wdata, 64'd0);
      chk({tag, "_wmask"}, 64'(wmask), 64'd0);
      chk({tag, "_wen"}, 64'(wen), 64'd0);
      chk({tag, "_size"}, 64'(size), 64'd0);
   endtask

   initial begin
      //            wen  size  addr                  wdata                 rdat                   mis  e_addr                e_mask e_wdata                e_rdata
      vecs[0]  = mk(0, 3'd3, 64'h8000_0010, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 WORD);
      vecs[1]  = mk(0, 3'd0, 64'h8000_0013, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'h76);
      vecs[2]  = mk(0, 3'd5, 64'h8000_0016, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'hFEDC);
      vecs[3]  = mk(0, 3'd2, 64'h8000_0014, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'hFFFF_FFFF_FEDC_BA98);
      vecs[4]  = mk(1, 3'd1, 64'h8000_0106, 64'h1234,              64'h1111_1111_1111_1111, 0, 64'h8000_0100, 8'hC0, 64'h1234_0000_0000_0000, 64'h0);
      vecs[5]  = mk(0, 3'd0, 64'h8000_0017, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'hFFFF_FFFF_FFFF_FFFE);
      vecs[6]  = mk(0, 3'd6, 64'h8000_0010, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'h7654_3210);
      vecs[7]  = mk(1, 3'd0, 64'h8000_0203, 64'hAB,                WORD,                  0, 64'h8000_0200, 8'h08, 64'hAB00_0000,          64'h0);
      vecs[8]  = mk(1, 3'd2, 64'h8000_0304, 64'hDEAD_BEEF,         WORD,                  0, 64'h8000_0300, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h0);
      vecs[9]  = mk(0, 3'd1, 64'h8000_0012, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'h7654);
      vecs[10] = mk(0, 3'd4, 64'h8000_0015, 64'h0,                 WORD,                  0, 64'h8000_0010, 8'h00, 64'h0,                 64'hBA);
      vecs[11] = mk(1, 3'd3, 64'h8000_0400, 64'h0123_4567_89AB_CDEF, WORD,                0, 64'h8000_0400, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
      vecs[12] = mk(0, 3'd2, 64'h8000_0002, 64'h0,                 WORD,                  1, 64'h0,         8'h00, 64'h0,                 64'h0);
      vecs[13] = mk(0, 3'd3, 64'h8000_0004, 64'h0,                 WORD,                  1, 64'h0,         8'h00, 64'h0,                 64'h0);
      vecs[14] = mk(1, 3'd1, 64'h8000_0001, 64'h55,                WORD,                  1, 64'h0,         8'h00, 64'h0,                 64'h0);

      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 15; i++) run_ls(i, vecs[i]);

      // Simultaneous IF + LS: LS wins, IF accepted in the LS response cycle
      @(negedge clk);
      ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_0010; ls_req_size = 3'd3;
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0004;
      #1;
      chk("arb_ls_ready", 64'(ls_req_ready), 64'd1);
      chk("arb_if_ready", 64'(if_req_ready), 64'd0);
      @(negedge clk);
      ls_req_valid = 1'b0;
      #1;
      chk("arb_cen_ls", 64'(cen), 64'd1);
      chk("arb_if_ready_req", 64'(if_req_ready), 64'd0);
      @(negedge clk);
      ram_ready = 1'b1; ram_data = WORD;
      @(negedge clk);
      ram_ready = 1'b0; ram_data = '0;
      #1;
      chk("arb_ls_valid", 64'(ls_resp_valid), 64'd1);
      chk("arb_ls_rdata", ls_resp_rdata, WORD);
      chk("arb_if_ready_resp", 64'(if_req_ready), 64'd1);
      @(negedge clk);
      if_req_valid = 1'b0;
      chk("arb_if_cen", 64'(cen), 64'd1);
      chk("arb_if_addr", addr, 64'h8000_0000);
      chk("arb_if_size", 64'(size), 64'd2);
      chk("arb_if_wen", 64'(wen), 64'd0);
      @(negedge clk);
      ram_ready = 1'b1; ram_data = WORD;
      @(negedge clk);
      ram_ready = 1'b0; ram_data = '0;
      chk("arb_if_valid", 64'(if_resp_valid), 64'd1);
      chk("arb_if_instr", 64'(if_resp_instr), 64'hFEDC_BA98);
      chk("arb_if_err", 64'(if_resp_err), 64'd0);
      chk("arb_if_ls_quiet", 64'(ls_resp_valid), 64'd0);
      @(negedge clk);
      chk("arb_if_pulse", 64'(if_resp_valid), 64'd0);

      // Misaligned fetch
      @(negedge clk);
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0002;
      @(negedge clk);
      if_req_valid = 1'b0;
      chk("if_mis_cen", 64'(cen), 64'd0);
      chk("if_mis_valid", 64'(if_resp_valid), 64'd1);
      chk("if_mis_err", 64'(if_resp_err), 64'd1);
      chk("if_mis_instr", 64'(if_resp_instr), 64'd0);

      // Timeout: responder never answers
      @(negedge clk);
      ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_req_addr = 64'h8000_0020; ls_req_size = 3'd3;
      @(negedge clk);
      ls_req_valid = 1'b0;
      chk("to_cen", 64'(cen), 64'd1);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d_valid", i), 64'(ls_resp_valid), 64'd0);
         chk($sformatf("to_wait%0d_busy", i), 64'(busy), 64'd1);
      end
      @(negedge clk);
      chk("to_valid", 64'(ls_resp_valid), 64'd1);
      chk("to_err", 64'(ls_resp_err), 64'd1);
      chk("to_rdata", ls_resp_rdata, 64'd0);
      chk("to_busy", 64'(busy), 64'd0);

      // Reset while in WAIT drops the response
      @(negedge clk);
      ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_req_addr = 64'h8000_0106;
      ls_req_wdata = 64'h1234; ls_req_size = 3'd1;
      @(negedge clk);
      ls_req_valid = 1'b0;
      @(negedge clk);
      chk("rw_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_all_zero("rst_wait");
      ram_ready = 1'b1; ram_data = WORD;
      @(negedge clk);
      ram_ready = 1'b0; ram_data = '0;
      @(negedge clk);
      chk("rw_no_ls_valid", 64'(ls_resp_valid), 64'd0);
      chk("rw_no_if_valid", 64'(if_resp_valid), 64'd0);
      run_ls(100, vecs[3]);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
